core_wb_unit: RTL



---
 rtl/core_wb_unit.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/core_wb_unit.sv
// Purpose: write-back stage; picks ALU/load/imm/PC+4 result, extracts sub-word loads, drives the register-file write port.
// Latency: register-file write is registered 1 cycle after accept (non-load or hit-load) or 1 cycle after a late ack.
// Backpressure: wb_stall_out (combinational) holds upstream while a load waits on wb_ack_in; a timeout abandons the load.
//
// Ports: clk/rst_n; memory-stage instruction (wb_enb, wb_kill, operands, wb_sel_in, wb_addr_lo_in, wb_rd_in, wb_we_in);
// data-memory ack (wb_ack_in, wb_mem_data_in); registered write port (wb_rf_we_out/addr/data); wb_stall_out; wb_timeout_out.
module core_wb_unit #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wb_enb,
    input  logic                       wb_kill,
    input  logic [XLEN-1:0]            wb_alu_result_in,
    input  logic [XLEN-1:0]            wb_mem_data_in,
    input  logic                       wb_ack_in,
    input  logic [XLEN-1:0]            wb_pc_4_in,
    input  logic [XLEN-1:0]            wb_imm_in,
    input  logic                       wb_is_load_in,
    input  logic [2:0]                 wb_sel_in,
    input  logic [$clog2(XLEN/8)-1:0]  wb_addr_lo_in,
    input  logic [RADDR_W-1:0]         wb_rd_in,
    input  logic                       wb_we_in,
    output logic                       wb_rf_we_out,
    output logic [RADDR_W-1:0]         wb_rf_addr_out,
    output logic [XLEN-1:0]            wb_rf_data_out,
    output logic                       wb_stall_out,
    output logic                       wb_timeout_out
);
    localparam int OFF_W = $clog2(XLEN/8);
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;

    // Controls captured when a load has to wait for its ack.
    logic [RADDR_W-1:0] lat_rd;
    logic               lat_we;
    logic [2:0]         lat_sel;
    logic [OFF_W-1:0]   lat_off;
    logic               lat_load;

    // Controls of the instruction currently retiring: live in IDLE, latched in WAIT.
    logic [RADDR_W-1:0] cur_rd;
    logic               cur_we;
    logic [2:0]         cur_sel;
    logic [OFF_W-1:0]   cur_off;
    logic               cur_load;

    logic [XLEN-1:0]    src;
    logic [XLEN-1:0]    shifted;
    logic [XLEN-1:0]    result;

    logic               in_idle;
    logic               in_wait;
    logic               do_write;
    logic               go_wait;
    logic               time_out;

    assign in_idle = (state == S_IDLE);
    assign in_wait = (state == S_WAIT);

    always_comb begin
        cur_rd   = wb_rd_in;
        cur_we   = wb_we_in;
        cur_sel  = wb_sel_in;
        cur_off  = wb_addr_lo_in;
        cur_load = wb_is_load_in;
        if (in_wait) begin
            cur_rd   = lat_rd;
            cur_we   = lat_we;
            cur_sel  = lat_sel;
            cur_off  = lat_off;
            cur_load = lat_load;
        end
    end

    // Sub-word extraction works on the value shifted down by the byte offset;
    // BP deliberately uses the unshifted source.
    always_comb begin
        src     = cur_load ? wb_mem_data_in : wb_alu_result_in;
        shifted = src >> {cur_off, 3'b000};
        case (cur_sel)
            3'd1:    result = {{(XLEN-8){1'b0}}, shifted[7:0]};
            3'd2:    result = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            3'd3:    result = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'd4:    result = {{(XLEN-16){1'b0}}, shifted[15:0]};
            3'd5:    result = wb_imm_in;
            3'd6:    result = wb_pc_4_in;
            default: result = src;
        endcase
    end

    assign do_write = (in_idle & wb_enb & ~wb_kill & (~wb_is_load_in | wb_ack_in))
                    | (in_wait & ~wb_kill & wb_ack_in);
    assign go_wait  = in_idle & wb_enb & ~wb_kill & wb_is_load_in & ~wb_ack_in;
    assign time_out = in_wait & ~wb_kill & ~wb_ack_in & (cnt == CNT_LAST);

    assign wb_stall_out = go_wait | (in_wait & ~wb_ack_in & ~wb_kill);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            cnt            <= '0;
            lat_rd         <= '0;
            lat_we         <= 1'b0;
            lat_sel        <= '0;
            lat_off        <= '0;
            lat_load       <= 1'b0;
            wb_rf_we_out   <= 1'b0;
            wb_rf_addr_out <= '0;
            wb_rf_data_out <= '0;
            wb_timeout_out <= 1'b0;
        end else begin
            wb_rf_we_out   <= do_write & cur_we & (cur_rd != '0);
            wb_timeout_out <= time_out;
            if (do_write & cur_we & (cur_rd != '0)) begin
                wb_rf_addr_out <= cur_rd;
                wb_rf_data_out <= result;
            end
            case (state)
                S_IDLE: begin
                    if (go_wait) begin
                        lat_rd   <= wb_rd_in;
                        lat_we   <= wb_we_in;
                        lat_sel  <= wb_sel_in;
                        lat_off  <= wb_addr_lo_in;
                        lat_load <= wb_is_load_in;
                        cnt      <= '0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Priority: kill, then ack, then timeout.
                    if (wb_kill || wb_ack_in || time_out) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
